// File: rtl/fp_add_front_end.sv
// fp_add_front_end: binary32 adder front end (unpack, align, mantissa add/sub), one register stage.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid_i, a_i, b_i    operand strobe and binary32 operands
//   out_valid_o             in_valid_i delayed one cycle
//   sign_*_o, exponent_*_o  unpacked signs and biased exponents
//   aligned_mantissa_*_o    24-bit mantissas after alignment to the larger exponent
//   exponent_out_o          larger exponent (exponent_a on a tie)
//   aligned_sign_o          sign of the larger-exponent operand (sign_a on a tie)
//   result_sign_o           sign of the larger-magnitude operand (0 on exact cancellation)
//   carry_out_o, aligned_result_o  25-bit raw mantissa result {carry, bits 23:0}
module fp_add_front_end (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        out_valid_o,
    output logic        sign_a_o,
    output logic        sign_b_o,
    output logic [7:0]  exponent_a_o,
    output logic [7:0]  exponent_b_o,
    output logic [23:0] aligned_mantissa_a_o,
    output logic [23:0] aligned_mantissa_b_o,
    output logic [7:0]  exponent_out_o,
    output logic        aligned_sign_o,
    output logic        result_sign_o,
    output logic        carry_out_o,
    output logic [23:0] aligned_result_o
);
    logic [7:0]  exp_a, exp_b, diff, exp_out_d;
    logic [23:0] man_a, man_b, al_a_d, al_b_d;
    logic        a_gt, b_gt, same, al_sign_d, res_sign_d;
    logic [24:0] res_d;
    always_comb begin
        exp_a      = a_i[30:23];
        exp_b      = b_i[30:23];
        man_a      = {|exp_a, a_i[22:0]};
        man_b      = {|exp_b, b_i[22:0]};
        a_gt       = exp_a > exp_b;
        b_gt       = exp_b > exp_a;
        diff       = a_gt ? exp_a - exp_b : exp_b - exp_a;
        // a logical shift by 24 or more naturally yields zero
        al_a_d     = b_gt ? man_a >> diff : man_a;
        al_b_d     = a_gt ? man_b >> diff : man_b;
        exp_out_d  = b_gt ? exp_b : exp_a;
        al_sign_d  = b_gt ? b_i[31] : a_i[31];
        same       = a_i[31] == b_i[31];
        res_d      = same ? {1'b0, al_a_d} + {1'b0, al_b_d}
                   : al_a_d >= al_b_d ? {1'b0, al_a_d - al_b_d} : {1'b0, al_b_d - al_a_d};
        res_sign_d = same ? a_i[31]
                   : al_a_d == al_b_d ? 1'b0
                   : al_a_d > al_b_d ? a_i[31] : b_i[31];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o          <= 1'b0;
            sign_a_o             <= 1'b0;
            sign_b_o             <= 1'b0;
            exponent_a_o         <= 8'd0;
            exponent_b_o         <= 8'd0;
            aligned_mantissa_a_o <= 24'd0;
            aligned_mantissa_b_o <= 24'd0;
            exponent_out_o       <= 8'd0;
            aligned_sign_o       <= 1'b0;
            result_sign_o        <= 1'b0;
            carry_out_o          <= 1'b0;
            aligned_result_o     <= 24'd0;
        end else begin
            out_valid_o          <= in_valid_i;
            sign_a_o             <= a_i[31];
            sign_b_o             <= b_i[31];
            exponent_a_o         <= exp_a;
            exponent_b_o         <= exp_b;
            aligned_mantissa_a_o <= al_a_d;
            aligned_mantissa_b_o <= al_b_d;
            exponent_out_o       <= exp_out_d;
            aligned_sign_o       <= al_sign_d;
            result_sign_o        <= res_sign_d;
            carry_out_o          <= res_d[24];
            aligned_result_o     <= res_d[23:0];
        end
    end
endmodule

// File: tb/tb_fp_add_front_end.sv
// tb_fp_add_front_end: directed table, random reference-model run and reset sequences for fp_add_front_end.
module tb_fp_add_front_end;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        out_valid, sign_a, sign_b, aligned_sign, result_sign, carry_out;
    logic [7:0]  exponent_a, exponent_b, exponent_out;
    logic [23:0] al_a, al_b, aligned_result;
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    fp_add_front_end dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .sign_a_o(sign_a), .sign_b_o(sign_b),
        .exponent_a_o(exponent_a), .exponent_b_o(exponent_b),
        .aligned_mantissa_a_o(al_a), .aligned_mantissa_b_o(al_b),
        .exponent_out_o(exponent_out), .aligned_sign_o(aligned_sign),
        .result_sign_o(result_sign), .carry_out_o(carry_out),
        .aligned_result_o(aligned_result)
    );

    typedef struct {
        logic [31:0] a, b;
        logic [7:0]  eo;
        logic [23:0] ma, mb;
        logic        c;
        logic [23:0] r;
        logic        asg, rsg;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (a=%h b=%h)", name, act, exp, a, b);
        end
    endtask

    // Independent reference: signed integer arithmetic on the aligned mantissas.
    function automatic vec_t model(input logic [31:0] xa, input logic [31:0] xb);
        vec_t m;
        int ea = int'(xa[30:23]);
        int eb = int'(xb[30:23]);
        int ma = (ea != 0 ? 32'h800000 : 0) + int'(xa[22:0]);
        int mb = (eb != 0 ? 32'h800000 : 0) + int'(xb[22:0]);
        int d = ea - eb;
        int s, mag;
        if (d > 0) mb = (d >= 24) ? 0 : mb / (1 << d);
        if (d < 0) ma = (-d >= 24) ? 0 : ma / (1 << -d);
        s = (xa[31] ? -ma : ma) + (xb[31] ? -mb : mb);
        mag = s < 0 ? -s : s;
        m.a = xa;
        m.b = xb;
        m.eo = d < 0 ? xb[30:23] : xa[30:23];
        m.ma = ma[23:0];
        m.mb = mb[23:0];
        m.c = mag[24];
        m.r = mag[23:0];
        m.asg = d < 0 ? xb[31] : xa[31];
        m.rsg = (xa[31] == xb[31]) ? xa[31] : (s < 0);
        return m;
    endfunction

    task automatic apply(input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input vec_t e);
        check("out_valid", 128'(out_valid), 128'(1'b1));
        check("sign_a", 128'(sign_a), 128'(e.a[31]));
        check("sign_b", 128'(sign_b), 128'(e.b[31]));
        check("exponent_a", 128'(exponent_a), 128'(e.a[30:23]));
        check("exponent_b", 128'(exponent_b), 128'(e.b[30:23]));
        check("exponent_out", 128'(exponent_out), 128'(e.eo));
        check("aligned_mantissa_a", 128'(al_a), 128'(e.ma));
        check("aligned_mantissa_b", 128'(al_b), 128'(e.mb));
        check("carry_out", 128'(carry_out), 128'(e.c));
        check("aligned_result", 128'(aligned_result), 128'(e.r));
        check("aligned_sign", 128'(aligned_sign), 128'(e.asg));
        check("result_sign", 128'(result_sign), 128'(e.rsg));
    endtask

    function automatic logic [127:0] all_out();
        return 128'({out_valid, sign_a, sign_b, exponent_a, exponent_b, al_a, al_b,
                     exponent_out, aligned_sign, result_sign, carry_out, aligned_result});
    endfunction

    initial begin
        vec_t tbl[10];
        logic [31:0] ra, rb;
        //            a             b             eo     ma         mb         c     r          asg   rsg
        tbl[0] = '{32'h3F800000, 32'h3F800000, 8'h7F, 24'h800000, 24'h800000, 1'b1, 24'h000000, 1'b0, 1'b0};
        tbl[1] = '{32'h40000000, 32'h3F800000, 8'h80, 24'h800000, 24'h400000, 1'b0, 24'hC00000, 1'b0, 1'b0};
        tbl[2] = '{32'h40000000, 32'hBF800000, 8'h80, 24'h800000, 24'h400000, 1'b0, 24'h400000, 1'b0, 1'b0};
        tbl[3] = '{32'h3F800000, 32'hBFC00000, 8'h7F, 24'h800000, 24'hC00000, 1'b0, 24'h400000, 1'b0, 1'b1};
        tbl[4] = '{32'h4B800000, 32'h3F800000, 8'h97, 24'h800000, 24'h000000, 1'b0, 24'h800000, 1'b0, 1'b0};
        tbl[5] = '{32'h3F800000, 32'hBF800000, 8'h7F, 24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[6] = '{32'h4B000000, 32'h3F800000, 8'h96, 24'h800000, 24'h000001, 1'b0, 24'h800001, 1'b0, 1'b0};
        tbl[7] = '{32'h3F800000, 32'hC0000000, 8'h80, 24'h400000, 24'h800000, 1'b0, 24'h400000, 1'b1, 1'b1};
        tbl[8] = '{32'h00000001, 32'h80000003, 8'h00, 24'h000001, 24'h000003, 1'b0, 24'h000002, 1'b0, 1'b1};
        tbl[9] = '{32'h7F800000, 32'h3F800000, 8'hFF, 24'h800000, 24'h000000, 1'b0, 24'h800000, 1'b0, 1'b0};

        // Reset held with live inputs: everything stays zero.
        a = 32'h3F800000;
        b = 32'hBFC00000;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_hold", all_out(), 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_valid", 128'(out_valid), 128'd0);

        foreach (tbl[i]) begin
            apply(tbl[i].a, tbl[i].b);
            check_all(tbl[i]);
        end

        // in_valid low: out_valid drops while the datapath keeps loading.
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'h40000000;
        b = 32'h3F800000;
        @(posedge clk);
        #1 check("valid_drop", 128'(out_valid), 128'd0);
        check("load_when_invalid", 128'(aligned_result), 128'(24'hC00000));

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) rb[30:23] = ra[30:23] + 8'($urandom_range(0, 26)) - 8'd13;
            if (i % 7 == 0) rb[30:23] = ra[30:23];
            apply(ra, rb);
            check_all(model(ra, rb));
            if (i == 5000) begin
                // Asynchronous reset between clock edges clears outputs immediately.
                #2 rst_n = 1'b0;
                #1 check("async_reset", all_out(), 128'd0);
                in_valid = 1'b0;
                @(posedge clk);
                #1 check("reset_still_zero", all_out(), 128'd0);
                #2 rst_n = 1'b1;
                @(posedge clk);
                #1 check("post_release_idle", 128'(out_valid), 128'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_add_front_end.md
Name: fp_add_front_end

Overview:
- Front end of the single-precision (IEEE-754 binary32) floating-point adder: unpack, align and add/subtract the mantissas of two operands.
- Unpack (mask) stage: splits both operands into sign, exponent and 24-bit mantissa with the hidden bit restored.
- Align stage: right-shifts the mantissa of the smaller-exponent operand and selects the result exponent and sign.
- ALU stage: adds or subtracts the aligned mantissas, producing a 25-bit raw result for the downstream normalize/round block.

Parameters:
- None. Format is fixed at 1-bit sign, 8-bit exponent, 23-bit fraction.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b are valid this cycle.
- a  input  32  operand A, binary32.
- b  input  32  operand B, binary32.
- out_valid  output  1  registered outputs hold a valid result.
- sign_a, sign_b  output  1 each  unpacked signs.
- exponent_a, exponent_b  output  8 each  unpacked biased exponents.
- aligned_mantissa_a, aligned_mantissa_b  output  24 each  mantissas after alignment.
- exponent_out  output  8  result exponent before normalization.
- aligned_sign  output  1  sign of the larger-exponent operand.
- result_sign  output  1  sign of the larger-magnitude operand.
- carry_out  output  1  bit 24 of the mantissa result.
- aligned_result  output  24  bits 23:0 of the mantissa result.

Behaviour:
- Clocking and reset:
  - One clock, one pipeline register; latency 1 cycle, throughput 1 result per cycle.
  - Datapath is combinational from a/b to the output registers.
  - rst_n low asynchronously clears every output to 0, including out_valid; this holds during reset and mid-operation.
  - out_valid equals in_valid delayed by one cycle.
  - Datapath registers load every cycle regardless of in_valid.
- Unpack:
  - sign = bit 31, exponent = bits 30:23.
  - mantissa = {hidden, bits 22:0}; hidden = 1 if exponent != 0, else 0 (denormal/zero).
  - No special handling of NaN/Inf; exponent 0xFF is treated as an ordinary value.
- Align:
  - If exponent_a > exponent_b: exponent_out = exponent_a, mantissa B shifted right by the difference, mantissa A unchanged.
  - If exponent_b > exponent_a: the mirror case.
  - If exponents are equal: exponent_out = exponent_a and neither mantissa is shifted.
  - Shifted-out bits are truncated; no guard or sticky bits.
  - A shift of 24 or more yields 0.
  - aligned_sign = sign of the larger-exponent operand; on an exponent tie, sign_a.
- ALU (25-bit result {carry_out, aligned_result}):
  - sign_a == sign_b: result = aligned_mantissa_a + aligned_mantissa_b, zero-extended to 25 bits.
  - Signs differ: result = larger aligned mantissa minus smaller; carry_out is always 0.
  - Signs differ and mantissas equal: result = 0.
  - result_sign:
    - signs equal: sign_a.
    - signs differ: sign of the operand with the larger aligned mantissa.
    - exact cancellation: 0.

Test Plan:
- Same sign, equal values: a=0x3F800000, b=0x3F800000 -> exponent_out=0x7F, both aligned mantissas=0x800000, carry_out=1, aligned_result=0x000000, aligned_sign=0, result_sign=0, out_valid one cycle after in_valid.
- Exponent difference 1, same sign: a=0x40000000, b=0x3F800000 -> exponent_out=0x80, aligned_mantissa_b=0x400000, carry_out=0, aligned_result=0xC00000.
- Differing signs: a=0x40000000, b=0xBF800000 -> aligned_result=0x400000, carry_out=0, aligned_sign=0, result_sign=0.
- Equal exponents, B larger magnitude: a=0x3F800000, b=0xBFC00000 -> aligned_result=0x400000, aligned_sign=0, result_sign=1.
- Large shift and cancellation:
  - a=0x4B800000, b=0x3F800000 (difference 24) -> aligned_mantissa_b=0, aligned_result=0x800000.
  - a=0x3F800000, b=0xBF800000 -> aligned_result=0, carry_out=0, result_sign=0.
- Reset mid-stream: drive 10000 random a/b with in_valid=1 and check each result against a reference model; pull rst_n low asynchronously between clock edges -> all outputs 0 immediately; on release, first out_valid appears one cycle after the next in_valid.
